sound_key_voice: RTL and testbench
==================================

# sound_key_voice

Single-voice tone generator that sits directly downstream of the melody sequencers (demo_sound*) in the DE2-115 synthesizer. It consumes their 8-bit PS/2-style key code (a held make code while a note sounds, 8'hF0 while silent) and turns it into a signed 16-bit square-wave sample stream with an attack/release envelope, one sample per codec sample strobe.

## Interface
- ATK_STEP, 8'd4: envelope increment per sample_tick in ATTACK.
- REL_STEP, 8'd2: envelope decrement per sample_tick in RELEASE.
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- sample_tick  in  1  one-cycle strobe at 48 kHz from the audio codec interface.
- key_code  in  8  make code from the sequencer; 8'hF0 means silent.
- sample_out  out  16  signed sample, two's complement.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- note_active  out  1  high when the FSM is not IDLE.
- note_index  out  4  current note 1..8, 0 when none.

## Operation
- Key decode: 2B,34,33,3B,42,4B,4C,52 map to note 1..8 (C4..C5). Phase increments (16-bit accumulator, 48 kHz): 357, 401, 450, 477, 535, 601, 674, 714.
- key_code is registered every clock into code_q; decode acts on code_q.
- Event classes on code_q vs. last accepted code:
  - note-on: valid code that differs from the current note;
  - note-off: 8'hF0;
  - otherwise no event. Unknown codes other than F0 are ignored, and state and note are kept.
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
  - Any state + note-on -> ATTACK. Latch note_index and increment.
  - ATTACK/SUSTAIN + note-off -> RELEASE.
  - ATTACK, on tick: level += ATK_STEP, saturating at 255. On reaching 255 -> SUSTAIN.
  - RELEASE, on tick: level -= REL_STEP, floored at 0. On reaching 0 -> IDLE, and note_index clears to 0.
  - A retrigger from RELEASE or SUSTAIN restarts ATTACK from the current level. The level is not zeroed.
  - The phase accumulator is never reset by note events, only by reset.
- Sample: on tick, phase += inc (mod 2^16).
  - Amplitude is amp = {1'b0, level, 7'b0}.
  - sample_out = phase[15] ? -amp : +amp, using the post-update phase and level.
  - In IDLE, sample_out = 0.

## Timing
- Reset values: sample_out=0, sample_valid=0, note_active=0, note_index=0, level=0, phase=0, state IDLE, code_q=8'hF0.
- key_code -> code_q takes 1 cycle. code_q event -> state/note_index/note_active takes 1 cycle, so total latency from key_code to note_active is 2 clocks.
- sample_valid pulses the cycle after each sample_tick, with sample_out updated in that same cycle.
- Event and tick in the same cycle:
  - The event is applied first.
  - The tick then advances the phase with the new increment and steps the envelope under the new state's rule.
  - Example: note-on plus tick from IDLE gives level = ATK_STEP.
- Back-to-back ticks are legal; each produces one sample_valid.
- Reset asserted mid-note forces all outputs to reset values on the next clock. No release tail.

## Configuration
- SOUND_VOICE_ENVELOPE_EN defined: the full ATTACK/RELEASE ramps described above.
- Not defined:
  - Note-on sets level=255 and goes straight to SUSTAIN.
  - Note-off sets level=0 and goes straight to IDLE.
  - ATK_STEP and REL_STEP are unused.
  - The same event-to-output latency applies.

## Structure
- Package sound_pkg holds:
  - the FSM state enum (voice_state_t);
  - the 8-entry make-code table and its phase-increment table;
  - the F0 break constant;
  - the 48 kHz assumption.
- Sub-module sound_voice_env holds the level register, FSM and saturation logic. The top keeps the key decode, phase accumulator and sample formatting.

## Test plan
- Reset, then key_code=8'h2B held, tick every 1042 clocks:
  - note_index=1 and note_active=1 two clocks after the code is applied;
  - level climbs by 4 per tick and reaches SUSTAIN on tick 64;
  - the phase after 10 ticks is 3570.
- From SUSTAIN, key_code=8'hF0:
  - RELEASE, level falls 2 per tick;
  - IDLE after 128 ticks, with note_index=0 and sample_out=0.
- During RELEASE at level 100, key_code=8'h42:
  - ATTACK resumes from 100, not 0;
  - note_index=5, increment 535.
- Unknown code 8'h1C while note 3 sounds: no state change; note_index stays 3.
- Note-on coincident with sample_tick from IDLE: sample_valid the next cycle with level=4, sample magnitude 4<<7=512.
- Reset asserted during ATTACK: next cycle all outputs 0 and state IDLE. Repeat with the macro undefined: note-on gives sample magnitude 255<<7=32640 on the first tick.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and note tables for the key-driven voice (see SOUND_VOICE_ENVELOPE_EN in
// sound_key_voice.sv for the envelope build option).
package sound_pkg;

    typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} voice_state_t;

    localparam logic [7:0]  KeyBreak     = 8'hF0;
    localparam int unsigned SampleRateHz = 48000;
    localparam int unsigned NumNotes     = 8;

    // Entry 0 is note 1 (C4); increments assume a 16-bit accumulator clocked at SampleRateHz.
    localparam logic [NumNotes-1:0][7:0] MakeCodes = {
        8'h52, 8'h4C, 8'h4B, 8'h42, 8'h3B, 8'h33, 8'h34, 8'h2B
    };
    localparam logic [NumNotes-1:0][15:0] PhaseIncs = {
        16'd714, 16'd674, 16'd601, 16'd535, 16'd477, 16'd450, 16'd401, 16'd357
    };

    // Returns 1..8 for a known make code, 0 otherwise.
    function automatic logic [3:0] code_to_note(input logic [7:0] code);
        logic [3:0] note;
        note = 4'd0;
        for (int unsigned i = 0; i < NumNotes; i++) begin
            if (code == MakeCodes[i[2:0]]) note = 4'(i + 1);
        end
        return note;
    endfunction

    function automatic logic [15:0] note_to_inc(input logic [3:0] note);
        logic [15:0] inc;
        inc = 16'd0;
        for (int unsigned i = 0; i < NumNotes; i++) begin
            if (note == 4'(i + 1)) inc = PhaseIncs[i[2:0]];
        end
        return inc;
    endfunction

endpackage

// File: rtl/sound_voice_env.sv
// Envelope FSM: level register, note latch and attack/release saturation.
// SOUND_VOICE_ENVELOPE_EN selects ramped envelopes; otherwise note-on/off switch instantly.
module sound_voice_env
    import sound_pkg::*;
#(
    parameter logic [7:0] ATK_STEP = 8'd4,
    parameter logic [7:0] REL_STEP = 8'd2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick_i,
    input  logic         note_on_i,
    input  logic         note_off_i,
    input  logic [3:0]   note_i,
    output voice_state_t state_o,
    output logic [7:0]   level_o,
    output logic [3:0]   note_o
);

    voice_state_t state_q;
    logic [7:0]   level_q;
    logic [3:0]   note_q;

`ifdef SOUND_VOICE_ENVELOPE_EN
    // State after the key event; a coincident tick then steps under this state's rule.
    voice_state_t ev_state;
    assign ev_state = note_on_i ? StAttack :
                      (note_off_i && (state_q == StAttack || state_q == StSustain)) ? StRelease :
                      state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            level_q <= 8'd0;
            note_q  <= 4'd0;
        end else begin
            if (note_on_i) note_q <= note_i;
            state_q <= ev_state;
            if (tick_i) begin
                case (ev_state)
                    StAttack: begin
                        if (level_q >= 8'd255 - ATK_STEP) begin
                            level_q <= 8'd255;
                            state_q <= StSustain;
                        end else begin
                            level_q <= level_q + ATK_STEP;
                        end
                    end
                    StRelease: begin
                        if (level_q <= REL_STEP) begin
                            level_q <= 8'd0;
                            state_q <= StIdle;
                            note_q  <= 4'd0;
                        end else begin
                            level_q <= level_q - REL_STEP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    logic unused_env;
    assign unused_env = ^{tick_i, ATK_STEP, REL_STEP};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            level_q <= 8'd0;
            note_q  <= 4'd0;
        end else if (note_on_i) begin
            state_q <= StSustain;
            level_q <= 8'd255;
            note_q  <= note_i;
        end else if (note_off_i && state_q != StIdle) begin
            state_q <= StIdle;
            level_q <= 8'd0;
            note_q  <= 4'd0;
        end
    end
`endif

    assign state_o = state_q;
    assign level_o = level_q;
    assign note_o  = note_q;

endmodule

// File: rtl/sound_key_voice.sv
// Single-voice square-wave generator driven by sequencer key codes.
// Define SOUND_VOICE_ENVELOPE_EN for attack/release ramps; default is instant on/off.
module sound_key_voice
    import sound_pkg::*;
#(
    parameter logic [7:0] ATK_STEP = 8'd4,
    parameter logic [7:0] REL_STEP = 8'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic [7:0]  key_code,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        note_active,
    output logic [3:0]  note_index
);

    logic [7:0]   code_q;
    logic [15:0]  phase_q;
    logic         sample_valid_q;
    logic [3:0]   code_note;
    logic [3:0]   env_note;
    logic [3:0]   ev_note;
    logic         note_on;
    logic         note_off;
    logic [15:0]  inc;
    logic [15:0]  amp;
    logic [7:0]   env_level;
    voice_state_t env_state;

    assign code_note = code_to_note(code_q);
    assign note_on   = (code_note != 4'd0) && (code_note != env_note);
    assign note_off  = (code_q == KeyBreak);

    // Note in force once this cycle's event is applied; a coincident tick uses its increment.
`ifdef SOUND_VOICE_ENVELOPE_EN
    assign ev_note = note_on ? code_note : env_note;
`else
    assign ev_note = note_on ? code_note : (note_off ? 4'd0 : env_note);
`endif
    assign inc = note_to_inc(ev_note);

    always_ff @(posedge clock) begin
        if (reset) begin
            code_q         <= KeyBreak;
            phase_q        <= 16'd0;
            sample_valid_q <= 1'b0;
        end else begin
            code_q         <= key_code;
            sample_valid_q <= sample_tick;
            if (sample_tick) phase_q <= phase_q + inc;
        end
    end

    sound_voice_env #(
        .ATK_STEP (ATK_STEP),
        .REL_STEP (REL_STEP)
    ) u_env (
        .clock      (clock),
        .reset      (reset),
        .tick_i     (sample_tick),
        .note_on_i  (note_on),
        .note_off_i (note_off),
        .note_i     (code_note),
        .state_o    (env_state),
        .level_o    (env_level),
        .note_o     (env_note)
    );

    // Formatted from the registered phase and level, so it settles with sample_valid.
    assign amp          = {1'b0, env_level, 7'b0};
    assign sample_out   = (env_state == StIdle) ? 16'd0 :
                          phase_q[15] ? (~amp + 16'd1) : amp;
    assign sample_valid = sample_valid_q;
    assign note_active  = (env_state != StIdle);
    assign note_index   = env_note;

endmodule

// File: tb/tb_sound_key_voice.sv
// Randomized self-checking bench for sound_key_voice against a behavioural voice model.
module tb_sound_key_voice;

`ifdef SOUND_VOICE_ENVELOPE_EN
    localparam bit EnvEn = 1'b1;
`else
    localparam bit EnvEn = 1'b0;
`endif
    localparam int TickGap = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [7:0]  key_code = 8'hF0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        note_active;
    logic [3:0]  note_index;
    logic [21:0] dut_outs;

    int n_total = 0;
    int n_bad = 0;

    int codes [8] = '{8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52};
    int incs  [8] = '{357, 401, 450, 477, 535, 601, 674, 714};

    // Model: state 0 idle, 1 attack, 2 sustain, 3 release.
    int         m_state = 0;
    int         m_level = 0;
    int         m_note = 0;
    int         m_phase = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_code = 8'hF0;

    sound_key_voice dut (
        .clock        (clock),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .key_code     (key_code),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .note_active  (note_active),
        .note_index   (note_index)
    );

    assign dut_outs = {sample_out, sample_valid, note_active, note_index};

    always #5 clock = ~clock;

    function automatic int decode(input logic [7:0] c);
        for (int i = 0; i < 8; i++) if (int'(c) == codes[i]) return i + 1;
        return 0;
    endfunction

    function automatic int mag(input logic [15:0] s);
        return s[15] ? 65536 - int'(s) : int'(s);
    endfunction

    function automatic logic [21:0] expected();
        int s;
        s = m_level * 128;
        if (m_phase >= 32768) s = -s;
        if (m_state == 0) s = 0;
        return {s[15:0], m_valid, m_state != 0, m_note[3:0]};
    endfunction

    task automatic model_edge();
        int n;
        if (reset) begin
            m_state = 0; m_level = 0; m_note = 0; m_phase = 0; m_valid = 1'b0; m_code = 8'hF0;
            return;
        end
        n = decode(m_code);
        if (n != 0 && n != m_note) begin
            m_note = n;
            if (EnvEn) m_state = 1;
            else begin m_state = 2; m_level = 255; end
        end else if (m_code == 8'hF0 && (m_state == 1 || m_state == 2)) begin
            if (EnvEn) m_state = 3;
            else begin m_state = 0; m_level = 0; m_note = 0; end
        end
        if (sample_tick) begin
            if (m_note != 0) m_phase = (m_phase + incs[m_note-1]) % 65536;
            if (EnvEn && m_state == 1) begin
                m_level = (m_level + 4 > 255) ? 255 : m_level + 4;
                if (m_level == 255) m_state = 2;
            end else if (EnvEn && m_state == 3) begin
                m_level = (m_level - 2 < 0) ? 0 : m_level - 2;
                if (m_level == 0) begin m_state = 0; m_note = 0; end
            end
        end
        m_valid = sample_tick;
        m_code = key_code;
    endtask

    task automatic step(input logic [7:0] k, input logic t, input logic r);
        @(negedge clock);
        key_code = k; sample_tick = t; reset = r;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic go_idle();
        int guard = 0;
        step(8'hF0, 1'b0, 1'b0);
        step(8'hF0, 1'b0, 1'b0);
        while (m_state != 0 && guard < 1000) begin
            step(8'hF0, guard[0], 1'b0);
            guard++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(8'hF0, 1'b1, 1'b1);
        n_total++;
        if (dut_outs !== 22'd0) begin
            n_bad++; $display("FAIL reset_outs: got %h want %h", dut_outs, 22'd0);
        end
        n_total++;
        if (dut.phase_q !== 16'd0) begin
            n_bad++; $display("FAIL reset_phase: got %0d want 0", dut.phase_q);
        end
        step(8'hF0, 1'b0, 1'b0);
        n_total++;
        if (dut_outs !== expected()) begin
            n_bad++; $display("FAIL reset_release: got %h want %h", dut_outs, expected());
        end
    endtask

    task automatic test_note_latency();
        step(8'h2B, 1'b0, 1'b0);
        n_total++;
        if (note_active !== 1'b0) begin
            n_bad++; $display("FAIL latency_1clk: note_active got %b want 0", note_active);
        end
        step(8'h2B, 1'b0, 1'b0);
        n_total++;
        if ({note_active, note_index} !== {1'b1, 4'd1}) begin
            n_bad++;
            $display("FAIL latency_2clk: got act=%b idx=%0d want act=1 idx=1",
                     note_active, note_index);
        end
    endtask

    task automatic test_attack();
        int k = 0;
        logic t;
        for (int c = 0; c < 70 * TickGap; c++) begin
            t = (c % TickGap) == TickGap - 1;
            step(8'h2B, t, 1'b0);
            n_total++;
            if (dut_outs !== expected()) begin
                n_bad++; $display("FAIL attack_outs c=%0d: got %h want %h", c, dut_outs, expected());
            end
            if (t) begin
                k++;
                if (k == 1 || k == 63 || k == 64) begin
                    int want;
                    want = (k == 1) ? (EnvEn ? 512 : 32640) :
                           (k == 63) ? (EnvEn ? 32256 : 32640) : 32640;
                    n_total++;
                    if (mag(sample_out) != want) begin
                        n_bad++;
                        $display("FAIL attack_mag tick=%0d: got %0d want %0d",
                                 k, mag(sample_out), want);
                    end
                end
                if (k == 10) begin
                    n_total++;
                    if (dut.phase_q !== 16'd3570) begin
                        n_bad++; $display("FAIL phase_10ticks: got %0d want 3570", dut.phase_q);
                    end
                end
            end
        end
    endtask

    task automatic test_release();
        int ticks = 0;
        int cyc = 0;
        logic t;
        step(8'hF0, 1'b0, 1'b0);
        step(8'hF0, 1'b0, 1'b0);
        while (note_active === 1'b1 && cyc < 2000) begin
            t = (cyc % 2) == 1;
            step(8'hF0, t, 1'b0);
            if (t) ticks++;
            cyc++;
            n_total++;
            if (dut_outs !== expected()) begin
                n_bad++; $display("FAIL release_outs c=%0d: got %h want %h", cyc, dut_outs, expected());
            end
        end
        n_total++;
        if (note_active !== 1'b0 || ticks != (EnvEn ? 128 : 0)) begin
            n_bad++;
            $display("FAIL release_ticks: got act=%b ticks=%0d want act=0 ticks=%0d",
                     note_active, ticks, EnvEn ? 128 : 0);
        end
        n_total++;
        if ({sample_out, note_index} !== 20'd0) begin
            n_bad++;
            $display("FAIL release_idle: got out=%h idx=%0d want 0", sample_out, note_index);
        end
    endtask

    task automatic test_retrigger();
        logic [15:0] p0;
        step(8'h2B, 1'b0, 1'b0);
        for (int c = 0; c < 140; c++) step(8'h2B, c[0], 1'b0);
        step(8'hF0, 1'b0, 1'b0);
        step(8'hF0, 1'b0, 1'b0);
        for (int c = 0; c < 50; c++) begin
            step(8'hF0, 1'b1, 1'b0);
            step(8'hF0, 1'b0, 1'b0);
        end
        step(8'h42, 1'b0, 1'b0);
        step(8'h42, 1'b0, 1'b0);
        n_total++;
        if ({note_active, note_index} !== {1'b1, 4'd5}) begin
            n_bad++;
            $display("FAIL retrig_note: got act=%b idx=%0d want act=1 idx=5",
                     note_active, note_index);
        end
        p0 = dut.phase_q;
        step(8'h42, 1'b1, 1'b0);
        n_total++;
        if (mag(sample_out) != (EnvEn ? 159 * 128 : 32640)) begin
            n_bad++;
            $display("FAIL retrig_level: got %0d want %0d", mag(sample_out),
                     EnvEn ? 159 * 128 : 32640);
        end
        n_total++;
        if (16'(dut.phase_q - p0) !== 16'd535) begin
            n_bad++; $display("FAIL retrig_inc: got %0d want 535", 16'(dut.phase_q - p0));
        end
        n_total++;
        if (dut_outs !== expected()) begin
            n_bad++; $display("FAIL retrig_outs: got %h want %h", dut_outs, expected());
        end
    endtask

    task automatic test_unknown();
        for (int c = 0; c < 6; c++) step(8'h33, c[0], 1'b0);
        for (int c = 0; c < 12; c++) begin
            step(8'h1C, c[0], 1'b0);
            n_total++;
            if ({note_active, note_index} !== {1'b1, 4'd3}) begin
                n_bad++;
                $display("FAIL unknown_hold c=%0d: got act=%b idx=%0d want act=1 idx=3",
                         c, note_active, note_index);
            end
            n_total++;
            if (dut_outs !== expected()) begin
                n_bad++; $display("FAIL unknown_outs c=%0d: got %h want %h", c, dut_outs, expected());
            end
        end
    endtask

    task automatic test_coincident();
        go_idle();
        step(8'h2B, 1'b0, 1'b0);
        step(8'h2B, 1'b1, 1'b0);
        n_total++;
        if (sample_valid !== 1'b1 || mag(sample_out) != (EnvEn ? 512 : 32640) ||
            note_index !== 4'd1) begin
            n_bad++;
            $display("FAIL coincident: got v=%b mag=%0d idx=%0d want v=1 mag=%0d idx=1",
                     sample_valid, mag(sample_out), note_index, EnvEn ? 512 : 32640);
        end
        n_total++;
        if (dut_outs !== expected()) begin
            n_bad++; $display("FAIL coincident_outs: got %h want %h", dut_outs, expected());
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            step(8'h2B, 1'b1, 1'b0);
            n_total++;
            if (sample_valid !== 1'b1 || dut_outs !== expected()) begin
                n_bad++; $display("FAIL b2b c=%0d: got %h want %h", c, dut_outs, expected());
            end
        end
        step(8'h2B, 1'b0, 1'b0);
        n_total++;
        if (sample_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_end: sample_valid got %b want 0", sample_valid);
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        step(8'h34, 1'b0, 1'b0);
        step(8'h34, 1'b0, 1'b0);
        step(8'h34, 1'b1, 1'b0);
        step(8'h34, 1'b1, 1'b1);
        n_total++;
        if (dut_outs !== 22'd0 || dut.phase_q !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got outs=%h phase=%0d want 0", dut_outs, dut.phase_q);
        end
        step(8'hF0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] k;
        int sel;
        k = 8'hF0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                sel = $urandom_range(0, 11);
                if (sel < 8) k = 8'(codes[sel]);
                else if (sel < 10) k = 8'hF0;
                else if (sel == 10) k = 8'h1C;
                else k = 8'($urandom);
            end
            step(k, $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
            n_total++;
            if (dut_outs !== expected()) begin
                n_bad++; $display("FAIL random c=%0d: got %h want %h", c, dut_outs, expected());
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_note_latency();
        test_attack();
        test_release();
        test_retrigger();
        test_unknown();
        test_coincident();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
